// File: rtl/dotprod_pkg.sv
// Shared widths and state encoding for the streaming dot-product engine.
//   pw_width   : full product width for DW-bit operands
//   sw_width   : lane-sum width for N products
//   accw_width : accumulator/result width covering MAXBEATS beats
//   cw_width   : beat-counter width able to hold MAXBEATS
package dotprod_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } acc_state_e;

    function automatic int unsigned pw_width(input int unsigned dw);
        return 2 * dw;
    endfunction

    function automatic int unsigned sw_width(input int unsigned n, input int unsigned dw);
        return pw_width(dw) + $clog2(n);
    endfunction

    function automatic int unsigned accw_width(input int unsigned n, input int unsigned dw,
                                               input int unsigned maxbeats);
        return sw_width(n, dw) + $clog2(maxbeats);
    endfunction

    function automatic int unsigned cw_width(input int unsigned maxbeats);
        return $clog2(maxbeats + 1);
    endfunction

endpackage

// File: rtl/dotprod_lane_sum.sv
// Masked N-lane multiplier and balanced adder tree, split into two
// combinational halves so the caller can register the products between them.
//   a, b    : N packed DW-bit operands (lane i at [i*DW +: DW])
//   mask    : lane i contributes 0 when mask[i] = 0
//   prod_c  : N masked PW-bit products (multiply half)
//   prod_q  : registered products fed back in (reduce half)
//   sum_c   : SW-bit sum of prod_q lanes
module dotprod_lane_sum
    import dotprod_pkg::*;
#(
    parameter  int unsigned N      = 8,
    parameter  int unsigned DW     = 16,
    parameter  int unsigned SIGNED = 0,
    localparam int unsigned PW     = pw_width(DW),
    localparam int unsigned SW     = sw_width(N, DW)
) (
    input  logic [N*DW-1:0] a,
    input  logic [N*DW-1:0] b,
    input  logic [N-1:0]    mask,
    output logic [N*PW-1:0] prod_c,
    input  logic [N*PW-1:0] prod_q,
    output logic [SW-1:0]   sum_c
);

    localparam int unsigned LVL = $clog2(N);
    localparam int unsigned P2  = 1 << LVL;

    logic [N*SW-1:0] leaf;

    // Per-lane operand extension, masked multiply and product extension to SW.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DW-1:0] a_l;
        logic [DW-1:0] b_l;
        logic [PW-1:0] a_x;
        logic [PW-1:0] b_x;
        logic [PW-1:0] p_q;

        assign a_l = a[i*DW +: DW];
        assign b_l = b[i*DW +: DW];
        assign p_q = prod_q[i*PW +: PW];

        if (SIGNED != 0) begin : g_sext
            assign a_x                  = PW'($signed(a_l));
            assign b_x                  = PW'($signed(b_l));
            assign leaf[i*SW +: SW]     = SW'($signed(p_q));
        end else begin : g_zext
            assign a_x                  = PW'(a_l);
            assign b_x                  = PW'(b_l);
            assign leaf[i*SW +: SW]     = SW'(p_q);
        end

        // The exact product always fits in PW bits, so the low PW bits of the
        // PW x PW multiply are correct for both signed and unsigned operands.
        assign prod_c[i*PW +: PW] = mask[i] ? PW'(a_x * b_x) : '0;
    end

    // Heap-ordered tree: leaves at [P2-1 .. 2*P2-2], padding leaves are zero.
    always_comb begin
        logic [SW-1:0] node [2*P2-1];
        for (int i = 0; i < int'(2 * P2 - 1); i++) begin
            node[i] = '0;
        end
        for (int i = 0; i < int'(N); i++) begin
            node[int'(P2) - 1 + i] = leaf[i*SW +: SW];
        end
        for (int i = int'(P2) - 2; i >= 0; i--) begin
            node[i] = node[2*i + 1] + node[2*i + 2];
        end
        sum_c = node[0];
    end

endmodule

// File: rtl/dotprod_stream.sv
// Streaming pipelined dot-product engine: multiply (P), reduce (S) and
// accumulate (A) stages, one full-precision result per in_last-terminated vector.
//   clk, nreset          : clock, asynchronous active-low reset
//   in_valid/in_ready    : input beat handshake
//   in_a, in_b, in_mask  : N lanes of DW-bit operand pairs plus lane enables
//   in_last              : final beat of the current vector
//   flush                : drop the partial vector and all in-flight beats
//   out_valid/out_ready  : result handshake
//   out_data             : dot product (ACCW bits, wraps past MAXBEATS beats)
//   out_beats            : beats in the vector, saturating at MAXBEATS
//   out_ovf              : vector had more than MAXBEATS beats
module dotprod_stream
    import dotprod_pkg::*;
#(
    parameter  int unsigned N        = 8,
    parameter  int unsigned DW       = 16,
    parameter  int unsigned MAXBEATS = 16,
    parameter  int unsigned SIGNED   = 0,
    localparam int unsigned PW       = pw_width(DW),
    localparam int unsigned SW       = sw_width(N, DW),
    localparam int unsigned ACCW     = accw_width(N, DW, MAXBEATS),
    localparam int unsigned CW       = cw_width(MAXBEATS)
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*DW-1:0]   in_a,
    input  logic [N*DW-1:0]   in_b,
    input  logic [N-1:0]      in_mask,
    input  logic              in_last,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACCW-1:0]   out_data,
    output logic [CW-1:0]     out_beats,
    output logic              out_ovf
);

    logic            en;
    logic            load;
    logic [N*PW-1:0] prod_c;
    logic [N*PW-1:0] prod_q;
    logic            valid_p;
    logic            last_p;
    logic [SW-1:0]   sum_c;
    logic [SW-1:0]   sum_q;
    logic            valid_s;
    logic            last_s;
    logic [ACCW-1:0] acc;
    logic [ACCW-1:0] sum_x;
    logic [ACCW-1:0] acc_sum;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic            cnt_full;
    acc_state_e      state_q;
    acc_state_e      state_d;

    // The whole pipeline stalls only while a result waits to be consumed.
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;
    assign load     = !flush && en && valid_s && last_s;

    dotprod_lane_sum #(
        .N      (N),
        .DW     (DW),
        .SIGNED (SIGNED)
    ) u_lane_sum (
        .a      (in_a),
        .b      (in_b),
        .mask   (in_mask),
        .prod_c (prod_c),
        .prod_q (prod_q),
        .sum_c  (sum_c)
    );

    if (SIGNED != 0) begin : g_sum_sext
        assign sum_x = ACCW'($signed(sum_q));
    end else begin : g_sum_zext
        assign sum_x = ACCW'(sum_q);
    end

    assign acc_sum  = acc + sum_x;
    // cnt saturates at MAXBEATS, so cnt+1 > MAXBEATS exactly when cnt is full.
    assign cnt_full = (cnt == CW'(MAXBEATS));
    assign cnt_inc  = cnt_full ? cnt : cnt + CW'(1);

    // Stage P: masked products.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            valid_p <= 1'b0;
            last_p  <= 1'b0;
            prod_q  <= '0;
        end else if (flush) begin
            valid_p <= 1'b0;
        end else if (en) begin
            valid_p <= in_valid;
            last_p  <= in_last;
            prod_q  <= prod_c;
        end
    end

    // Stage S: lane sum.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            valid_s <= 1'b0;
            last_s  <= 1'b0;
            sum_q   <= '0;
        end else if (flush) begin
            valid_s <= 1'b0;
        end else if (en) begin
            valid_s <= valid_p;
            last_s  <= last_p;
            sum_q   <= sum_c;
        end
    end

    // Stage A: cross-beat accumulation and result capture.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_beats <= '0;
            out_ovf   <= 1'b0;
        end else if (flush) begin
            acc <= '0;
            cnt <= '0;
        end else if (en && valid_s) begin
            if (last_s) begin
                out_data  <= acc_sum;
                out_beats <= cnt_inc;
                out_ovf   <= cnt_full;
                acc       <= '0;
                cnt       <= '0;
            end else begin
                acc <= acc_sum;
                cnt <= cnt_inc;
            end
        end
    end

    // A new result may replace one being consumed on the same edge.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Tracks whether stage A holds a partial vector.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else if (en && valid_s) begin
            state_d = last_s ? IDLE : RUN;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_dotprod_stream.sv
// Directed bench for dotprod_stream: three instances (unsigned, signed,
// unsigned with MAXBEATS=4) share one input stream and one out_ready.
module tb_dotprod_stream;

    typedef struct packed {
        logic [21:0] d;
        logic [4:0]  b;
        logic        o;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  mask;
        logic [21:0] exp_u;
        logic [21:0] exp_s;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_mask;
    logic        in_last;
    logic        flush;
    logic        out_ready;

    logic        in_ready_u, out_valid_u, out_ovf_u;
    logic [21:0] out_data_u;
    logic [4:0]  out_beats_u;
    logic        in_ready_s, out_valid_s, out_ovf_s;
    logic [21:0] out_data_s;
    logic [4:0]  out_beats_s;
    logic        in_ready_m, out_valid_m, out_ovf_m;
    logic [19:0] out_data_m;
    logic [2:0]  out_beats_m;

    int checks = 0;
    int errors = 0;
    res_t q_u[$];
    res_t q_s[$];
    res_t q_m[$];
    vec_t tbl [8];

    always #5 clk = ~clk;

    dotprod_stream #(.N(4), .DW(8), .MAXBEATS(16), .SIGNED(0)) u_uns (
        .clk(clk), .nreset(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
        .in_a(in_a), .in_b(in_b), .in_mask(in_mask), .in_last(in_last), .flush(flush),
        .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u),
        .out_beats(out_beats_u), .out_ovf(out_ovf_u));

    dotprod_stream #(.N(4), .DW(8), .MAXBEATS(16), .SIGNED(1)) u_sgn (
        .clk(clk), .nreset(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_a(in_a), .in_b(in_b), .in_mask(in_mask), .in_last(in_last), .flush(flush),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .out_beats(out_beats_s), .out_ovf(out_ovf_s));

    dotprod_stream #(.N(4), .DW(8), .MAXBEATS(4), .SIGNED(0)) u_mb4 (
        .clk(clk), .nreset(rst_n), .in_valid(in_valid), .in_ready(in_ready_m),
        .in_a(in_a), .in_b(in_b), .in_mask(in_mask), .in_last(in_last), .flush(flush),
        .out_valid(out_valid_m), .out_ready(out_ready), .out_data(out_data_m),
        .out_beats(out_beats_m), .out_ovf(out_ovf_m));

    // Record every completed result transfer, in order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid_u && out_ready) q_u.push_back(res_t'{d: out_data_u, b: out_beats_u, o: out_ovf_u});
            if (out_valid_s && out_ready) q_s.push_back(res_t'{d: out_data_s, b: out_beats_s, o: out_ovf_s});
            if (out_valid_m && out_ready) q_m.push_back(res_t'{d: 22'(out_data_m), b: 5'(out_beats_m), o: out_ovf_m});
        end
    end

    function automatic logic [31:0] pack4(input logic [7:0] l0, input logic [7:0] l1,
                                          input logic [7:0] l2, input logic [7:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic res_t mk(input logic [21:0] d, input int unsigned b, input logic o);
        return res_t'{d: d, b: 5'(b), o: o};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_u.delete();
        q_s.delete();
        q_m.delete();
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] m,
                        input logic l);
        int cyc = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_mask  = m;
        in_last  = l;
        @(negedge clk);
        while (!in_ready_u && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (!in_ready_u) chk("send_stuck", 64'(in_ready_u), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait (bounded) for n results on every instance, then confirm no extras.
    task automatic wait_res(input string nm, input int n);
        int cyc = 0;
        while ((q_u.size() < n || q_s.size() < n || q_m.size() < n) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        repeat (4) @(negedge clk);
        chk({nm, "_count_u"}, 64'(q_u.size()), 64'(n));
        chk({nm, "_count_s"}, 64'(q_s.size()), 64'(n));
        chk({nm, "_count_m"}, 64'(q_m.size()), 64'(n));
    endtask

    task automatic cmp_res(input string nm, input int idx, input res_t eu, input res_t es,
                           input res_t em);
        if (idx < q_u.size()) chk({nm, "_u"}, 64'(q_u[idx]), 64'(eu));
        if (idx < q_s.size()) chk({nm, "_s"}, 64'(q_s[idx]), 64'(es));
        if (idx < q_m.size()) chk({nm, "_m"}, 64'(q_m[idx]), 64'(em));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mask = '0;
        in_last = 1'b0; flush = 1'b0; out_ready = 1'b1;

        tbl[0] = '{pack4(8'd1, 8'd2, 8'd3, 8'd4), pack4(8'd5, 8'd6, 8'd7, 8'd8), 4'hF, 22'd70, 22'd70};
        tbl[1] = '{pack4(8'hFF, 8'h02, 8'hFD, 8'h04), pack4(8'd1, 8'd1, 8'd1, 8'd1), 4'hF, 22'd514, 22'd2};
        tbl[2] = '{pack4(8'd9, 8'd9, 8'd9, 8'd9), pack4(8'd1, 8'd1, 8'd1, 8'd1), 4'b0101, 22'd18, 22'd18};
        tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF, 22'd260100, 22'd4};
        tbl[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h0, 22'd0, 22'd0};
        tbl[5] = '{pack4(8'h80, 8'h7F, 8'h01, 8'h00), pack4(8'h7F, 8'h80, 8'hFF, 8'h55), 4'hF,
                   22'd32767, 22'(-32513)};
        tbl[6] = '{pack4(8'd1, 8'd2, 8'd3, 8'd4), pack4(8'd5, 8'd6, 8'd7, 8'd8), 4'b1010, 22'd44, 22'd44};
        tbl[7] = '{32'h8080_8080, 32'h8080_8080, 4'hF, 22'd65536, 22'd65536};

        // Reset state.
        #3;
        chk("rst_out_valid", 64'(out_valid_u), 64'd0);
        chk("rst_out_data", 64'(out_data_u), 64'd0);
        chk("rst_out_beats", 64'(out_beats_u), 64'd0);
        chk("rst_out_ovf", 64'(out_ovf_u), 64'd0);
        chk("rst_in_ready", 64'(in_ready_u), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        align();

        // Single-beat latency: out_valid appears after the second edge past acceptance.
        send(tbl[0].a, tbl[0].b, tbl[0].mask, 1'b1);
        @(negedge clk); chk("lat_e0_valid", 64'(out_valid_u), 64'd0);
        @(negedge clk); chk("lat_e1_valid", 64'(out_valid_u), 64'd0);
        @(negedge clk); chk("lat_e2_valid", 64'(out_valid_u), 64'd1);
        chk("lat_data", 64'(out_data_u), 64'd70);
        chk("lat_beats", 64'(out_beats_u), 64'd1);
        chk("lat_ovf", 64'(out_ovf_u), 64'd0);
        wait_res("lat", 1);
        clear_q();
        align();

        // Table vectors back to back.
        for (int i = 0; i < 8; i++) send(tbl[i].a, tbl[i].b, tbl[i].mask, 1'b1);
        wait_res("tbl", 8);
        for (int i = 0; i < 8; i++)
            cmp_res($sformatf("tbl%0d", i), i, mk(tbl[i].exp_u, 1, 1'b0),
                    mk(tbl[i].exp_s, 1, 1'b0), mk(tbl[i].exp_u, 1, 1'b0));
        clear_q();
        align();

        // Backpressure: stall the output for 5 cycles mid-stream.
        fork
            begin
                for (int i = 0; i < 8; i++) send(tbl[i].a, tbl[i].b, tbl[i].mask, 1'b1);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk($sformatf("bp_in_ready%0d", k), 64'(in_ready_u), 64'd0);
                    chk($sformatf("bp_valid%0d", k), 64'(out_valid_u), 64'd1);
                    chk($sformatf("bp_hold%0d", k), 64'(out_data_u), 64'(tbl[1].exp_u));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_res("bp", 8);
        for (int i = 0; i < 8; i++)
            cmp_res($sformatf("bp%0d", i), i, mk(tbl[i].exp_u, 1, 1'b0),
                    mk(tbl[i].exp_s, 1, 1'b0), mk(tbl[i].exp_u, 1, 1'b0));
        clear_q();
        align();

        // Three beats of -128 x -128 in every lane.
        for (int i = 0; i < 3; i++) send(32'h8080_8080, 32'h8080_8080, 4'hF, i == 2);
        wait_res("b3", 1);
        cmp_res("b3", 0, mk(22'd196608, 3, 1'b0), mk(22'd196608, 3, 1'b0), mk(22'd196608, 3, 1'b0));
        clear_q();
        align();

        // Six all-ones beats: overflows the MAXBEATS=4 instance only.
        for (int i = 0; i < 6; i++) send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF, i == 5);
        wait_res("b6", 1);
        cmp_res("b6", 0, mk(22'd1560600, 6, 1'b0), mk(22'd24, 6, 1'b0), mk(22'd512024, 4, 1'b1));
        clear_q();
        align();

        // Flush after two beats of a four-beat vector, with a beat presented during flush.
        send(tbl[0].a, tbl[0].b, tbl[0].mask, 1'b0);
        send(tbl[0].a, tbl[0].b, tbl[0].mask, 1'b0);
        in_valid = 1'b1; in_a = tbl[0].a; in_b = tbl[0].b; in_mask = tbl[0].mask; in_last = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready_u), 64'd1);
        align();
        flush = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        send(tbl[2].a, tbl[2].b, tbl[2].mask, 1'b0);
        send(tbl[2].a, tbl[2].b, tbl[2].mask, 1'b1);
        wait_res("flush", 1);
        cmp_res("flush", 0, mk(22'd36, 2, 1'b0), mk(22'd36, 2, 1'b0), mk(22'd36, 2, 1'b0));
        clear_q();
        align();

        // Flush must not disturb a completed result waiting at the output.
        out_ready = 1'b0;
        send(tbl[0].a, tbl[0].b, tbl[0].mask, 1'b1);
        repeat (3) @(negedge clk);
        chk("fkeep_valid_pre", 64'(out_valid_u), 64'd1);
        align();
        flush = 1'b1;
        align();
        flush = 1'b0;
        @(negedge clk);
        chk("fkeep_valid", 64'(out_valid_u), 64'd1);
        chk("fkeep_data", 64'(out_data_u), 64'd70);
        align();
        out_ready = 1'b1;
        wait_res("fkeep", 1);
        cmp_res("fkeep", 0, mk(22'd70, 1, 1'b0), mk(22'd70, 1, 1'b0), mk(22'd70, 1, 1'b0));
        clear_q();
        align();

        // Asynchronous reset mid-vector while a result is pending.
        out_ready = 1'b0;
        send(tbl[0].a, tbl[0].b, tbl[0].mask, 1'b1);
        send(tbl[1].a, tbl[1].b, tbl[1].mask, 1'b0);
        @(posedge clk);
        #3;
        chk("arst_pre_valid", 64'(out_valid_u), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid_u", 64'(out_valid_u), 64'd0);
        chk("arst_data_u", 64'(out_data_u), 64'd0);
        chk("arst_beats_u", 64'(out_beats_u), 64'd0);
        chk("arst_ovf_u", 64'(out_ovf_u), 64'd0);
        chk("arst_valid_s", 64'(out_valid_s), 64'd0);
        chk("arst_data_s", 64'(out_data_s), 64'd0);
        chk("arst_in_ready", 64'(in_ready_u), 64'd1);
        clear_q();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        align();
        send(tbl[1].a, tbl[1].b, tbl[1].mask, 1'b1);
        wait_res("arst", 1);
        cmp_res("arst", 0, mk(22'd514, 1, 1'b0), mk(22'd2, 1, 1'b0), mk(22'd514, 1, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dotprod_stream.md
Name: dotprod_stream

Overview:
- Streaming, pipelined dot-product engine for the arithmetic group.
- Each accepted beat carries N element pairs, and a vector spans one or more beats, terminated by in_last.
- The block multiplies the lanes, reduces them with an adder tree, and accumulates across beats.
- It emits one full-precision result per vector over a valid/ready output, with signed/unsigned selection, per-lane masking and beat-count overflow reporting.

Parameters:
- N, 8, lanes (element pairs) per beat, >=1
- DW, 16, element width in bits
- MAXBEATS, 16, maximum beats per vector covered by full-precision guarantee, >=1
- SIGNED, 0, 1 = two's-complement operands and result, 0 = unsigned

Ports:
- clk  in  1  clock, rising edge
- nreset  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready at rising edge
- in_a  in  N*DW  lane i = in_a[i*DW +: DW]
- in_b  in  N*DW  lane i = in_b[i*DW +: DW]
- in_mask  in  N  lane i contributes 0 when in_mask[i]=0
- in_last  in  1  final beat of current vector
- flush  in  1  synchronous abort of partial vector and in-flight beats
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_data  out  ACCW  dot product, ACCW = 2*DW + clog2(N) + clog2(MAXBEATS)
- out_beats  out  CW  beats in vector, CW = clog2(MAXBEATS+1), saturating at MAXBEATS
- out_ovf  out  1  vector had more than MAXBEATS beats

Behaviour:
- Reset (nreset low, asynchronous): all valids 0, accumulator 0, beat counter 0, out_data 0, out_beats 0, out_ovf 0; state IDLE. in_ready is 1 after reset.
- Widths: PW = 2*DW product, SW = PW + clog2(N) lane sum, ACCW as above. Operands are extended per SIGNED (sign- or zero-extend) before the multiply. No truncation below ACCW.
- Pipeline stall: en = !(out_valid && !out_ready); in_ready = en. All stages advance only when en=1.
- Stage P (edge E0, beat accepted): register N masked products, plus valid_p and last_p.
- Stage S (E1): register the lane sum (SW bits), plus valid_s and last_s.
- Stage A (E2), when valid_s:
  - Not last: acc <= acc + sum; cnt increments, saturating at MAXBEATS.
  - Last: out_data <= acc + sum; out_beats <= cnt+1 (saturated); out_ovf <= (cnt+1 > MAXBEATS). Then out_valid <= 1, acc <= 0, cnt <= 0.
- Latency: last beat accepted at E0 -> out_valid=1 after E2.
- Throughput: one beat per cycle; single-beat vectors give one result per cycle while out_ready=1.
- Output handshake: out_data, out_beats and out_ovf stay stable while out_valid && !out_ready. A result transfer and a new result load in the same edge are legal (en=1). out_valid falls only when the result is consumed and no new result arrives.
- Accumulator state machine (tracks the partial vector at stage A):
  - IDLE -> RUN on a non-last valid_s.
  - RUN -> IDLE on a last valid_s.
  - IDLE -> IDLE on a last valid_s (single-beat vector).
- Overflow: beyond MAXBEATS beats the result wraps modulo 2^ACCW and out_ovf=1.
- flush=1 (takes priority over en):
  - Clears valid_p, valid_s, acc and cnt; state -> IDLE.
  - Any beat presented that cycle is dropped; in_ready still reads en.
  - A completed result in the output register is kept.
- Masked lanes contribute exactly 0 regardless of in_a/in_b. All-zero mask still counts as a beat.
- N=1: the adder tree degenerates to a wire register; clog2(1)=0.
- MAXBEATS=1: CW=1; any multi-beat vector sets out_ovf.

Decomposition:
- Package dotprod_pkg: width functions/constants PW(DW), SW(N,DW), ACCW(N,DW,MAXBEATS), CW(MAXBEATS); state encoding IDLE=0, RUN=1.
- Sub-module dotprod_lane_sum: combinational masked N-lane multiply plus balanced adder tree, parameters N, DW, SIGNED, output SW bits. The top instantiates it between the product and sum registers, or splits its multiply/reduce halves across stages P/S.

Test Plan:
- N=4, DW=8, unsigned, single beat a={1,2,3,4}, b={5,6,7,8}, mask=4'hF, last=1, out_ready=1 -> out_data=70, out_beats=1, out_ovf=0, out_valid 2 edges after acceptance.
- SIGNED=1, DW=8, N=4: a={-128,-128,-128,-128}, b={-128,-128,-128,-128}, 3 beats -> out_data=196608, out_beats=3; a={-1,2,-3,4}, b={1,1,1,1} -> out_data=2.
- Backpressure: 8 back-to-back single-beat vectors, out_ready low for 5 cycles mid-stream -> in_ready low while stalled, no lost or duplicated results, out_data stable during the stall, results in order.
- MAXBEATS=4: 6-beat vector of all-ones, DW=8, N=4 -> out_beats=4, out_ovf=1, out_data=6*4*255*255 mod 2^ACCW.
- Mask 4'b0101 with a={9,9,9,9}, b={1,1,1,1} -> out_data=18. flush asserted after beat 2 of a 4-beat vector -> partial discarded; next vector's result is uncorrupted.
- Reset asserted asynchronously mid-vector with out_valid=1 -> all outputs 0 immediately. After release, a fresh vector produces the correct result.
